// File: rtl/region_pkg.sv
// Shared constants, FSM encoding and region word layout for the
// alarm-region bank controller and the region comparator.
package region_pkg;

    localparam int POINTS     = 811;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 18;
    localparam int NUM_REGION = 3;

    localparam logic [ADDR_W-1:0] POINTS_A = ADDR_W'(POINTS);

    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_ARMED = 2;
    localparam int S_SWAP  = 3;
    localparam int S_ERR   = 4;
    localparam int NUM_ST  = 5;

    typedef enum logic [NUM_ST-1:0] {
        IDLE  = 5'b00001,
        LOAD  = 5'b00010,
        ARMED = 5'b00100,
        SWAP  = 5'b01000,
        ERR   = 5'b10000
    } state_t;

    // Region word: boundary in [15:0]; 16'hFFFF disables the check.
    localparam int BOUND_LSB = 0;
    localparam int BOUND_MSB = 15;
    localparam logic [15:0] BOUND_NO_CHECK = 16'hFFFF;

    typedef struct packed {
        logic [DATA_W-17:0] rsvd;
        logic [15:0]        bound;
    } region_word_t;

endpackage

// File: rtl/region_bank_ctrl_edge_det.sv
// Two-flop history rise/fall detector (history 01 = rise, 10 = fall).
// Shared between the bank controller and the comparator.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) hist <= 2'b00;
        else     hist <= {hist[0], din};
    end

    assign rise = (hist == 2'b01);
    assign fall = (hist == 2'b10);

endmodule

// File: rtl/region_bank_ctrl.sv
// Double-buffer controller for the inner/middle/outer region RAMs:
// loads the shadow bank in order and swaps banks at a scan boundary.
module region_bank_ctrl
    import region_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cycle_enable,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_region,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_commit,
    input  logic              cfg_abort,
    input  logic              cmp_rden,
    input  logic [ADDR_W-1:0] cmp_rdaddr,
    output logic              ram_rden,
    output logic [ADDR_W:0]   ram_rdaddr,
    output logic [2:0]        ram_wren,
    output logic [ADDR_W:0]   ram_wraddr,
    output logic [DATA_W-1:0] ram_wrdata,
    output logic              active_bank,
    output logic              swap_done,
    output logic              cfg_err
);

    state_t state, state_nxt;

    logic [NUM_REGION-1:0][ADDR_W-1:0] exp_q, exp_nxt;
    logic [ADDR_W-1:0]     exp_sel;
    logic [NUM_REGION-1:0] wr_onehot;
    logic beat, beat_ok, beat_bad;
    logic start_ok, all_full, err_set;
    logic fall, rise_unused;

    edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (cycle_enable),
        .rise (rise_unused),
        .fall (fall)
    );

    assign ram_rden   = cmp_rden;
    assign ram_rdaddr = {active_bank, cmp_rdaddr};
    assign cfg_ready  = state[S_LOAD];

    always_comb begin
        case (cfg_region)
            2'd0:    exp_sel = exp_q[0];
            2'd1:    exp_sel = exp_q[1];
            2'd2:    exp_sel = exp_q[2];
            default: exp_sel = '0;
        endcase
    end

    // Abort outranks a beat arriving in the same cycle.
    assign beat     = cfg_valid & cfg_ready & ~cfg_abort;
    assign beat_ok  = beat & (cfg_region != 2'd3)
                    & (cfg_addr == exp_sel) & (exp_sel != POINTS_A);
    assign beat_bad = beat & ~beat_ok;
    assign start_ok = cfg_start & ~cfg_abort & (state[S_IDLE] | state[S_ERR]);

    always_comb begin
        wr_onehot = '0;
        if (beat_ok) wr_onehot = NUM_REGION'(3'b001 << cfg_region);
    end

    // The commit check sees a beat written in the same cycle.
    always_comb begin
        all_full = 1'b1;
        for (int r = 0; r < NUM_REGION; r++) begin
            exp_nxt[r] = exp_q[r] + {{(ADDR_W-1){1'b0}}, wr_onehot[r]};
            if (exp_nxt[r] != POINTS_A) all_full = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        unique case (1'b1)
            state[S_IDLE]: begin
                if (start_ok) state_nxt = LOAD;
            end
            state[S_LOAD]: begin
                if (cfg_abort) begin
                    state_nxt = IDLE;
                end else if (beat_bad) begin
                    state_nxt = ERR;
                    err_set   = 1'b1;
                end else if (cfg_commit) begin
                    if (all_full) begin
                        state_nxt = ARMED;
                    end else begin
                        state_nxt = ERR;
                        err_set   = 1'b1;
                    end
                end
            end
            state[S_ARMED]: begin
                if (cfg_abort) state_nxt = IDLE;
                else if (fall) state_nxt = SWAP;
            end
            state[S_SWAP]: begin
                state_nxt = IDLE;
            end
            state[S_ERR]: begin
                if (cfg_abort)     state_nxt = IDLE;
                else if (start_ok) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active_bank <= 1'b0;
            swap_done   <= 1'b0;
            cfg_err     <= 1'b0;
            ram_wren    <= '0;
            ram_wraddr  <= '0;
            ram_wrdata  <= '0;
            exp_q       <= '0;
        end else begin
            state     <= state_nxt;
            swap_done <= state_nxt[S_SWAP];
            if (state_nxt[S_SWAP]) active_bank <= ~active_bank;

            if (start_ok)     cfg_err <= 1'b0;
            else if (err_set) cfg_err <= 1'b1;

            ram_wren <= wr_onehot;
            if (beat_ok) begin
                ram_wraddr <= {~active_bank, cfg_addr};
                ram_wrdata <= cfg_data;
            end

            if (start_ok) exp_q <= '0;
            else          exp_q <= exp_nxt;
        end
    end

endmodule

// File: tb/tb_region_bank_ctrl.sv
// Scoreboard bench for region_bank_ctrl: directed loads, errors,
// aborts, mid-scan commit and reset during load.
module tb_region_bank_ctrl;

    localparam int P = 811;

    typedef struct packed {
        logic [2:0]  wren;
        logic [10:0] addr;
        logic [17:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cycle_enable;
    logic        cfg_start;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_region;
    logic [9:0]  cfg_addr;
    logic [17:0] cfg_data;
    logic        cfg_commit;
    logic        cfg_abort;
    logic        cmp_rden;
    logic [9:0]  cmp_rdaddr;
    logic        ram_rden;
    logic [10:0] ram_rdaddr;
    logic [2:0]  ram_wren;
    logic [10:0] ram_wraddr;
    logic [17:0] ram_wrdata;
    logic        active_bank;
    logic        swap_done;
    logic        cfg_err;

    int total = 0;
    int bad   = 0;
    wr_t  wq[$];
    logic sq[$];

    region_bank_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cycle_enable (cycle_enable),
        .cfg_start    (cfg_start),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_region   (cfg_region),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_commit   (cfg_commit),
        .cfg_abort    (cfg_abort),
        .cmp_rden     (cmp_rden),
        .cmp_rdaddr   (cmp_rdaddr),
        .ram_rden     (ram_rden),
        .ram_rdaddr   (ram_rdaddr),
        .ram_wren     (ram_wren),
        .ram_wraddr   (ram_wraddr),
        .ram_wrdata   (ram_wrdata),
        .active_bank  (active_bank),
        .swap_done    (swap_done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] data_of(int r, int a);
        logic [1:0] rr;
        logic [9:0] aa;
        rr = r[1:0];
        aa = a[9:0];
        return {rr, 6'h15, aa};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write and every swap must match a queued expectation.
    always @(negedge clk) begin
        if (ram_wren != 3'b000) begin
            wr_t e;
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: wren=%b addr=%0h", ram_wren, ram_wraddr);
            end else begin
                e = wq.pop_front();
                if (ram_wren !== e.wren || ram_wraddr !== e.addr || ram_wrdata !== e.data) begin
                    bad++;
                    $display("FAIL write: got %b/%0h/%0h want %b/%0h/%0h",
                             ram_wren, ram_wraddr, ram_wrdata, e.wren, e.addr, e.data);
                end
            end
        end
        if (swap_done) begin
            total++;
            if (sq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_swap: bank=%0d", active_bank);
            end else if (active_bank !== sq.pop_front()) begin
                bad++;
                $display("FAIL swap_bank: got %0d", active_bank);
            end
        end
    end

    task automatic send_beat(int r, int a, logic ok, logic shadow);
        wr_t e;
        cfg_valid  = 1'b1;
        cfg_region = r[1:0];
        cfg_addr   = a[9:0];
        cfg_data   = data_of(r, a);
        if (ok) begin
            e.wren = 3'b001 << r;
            e.addr = {shadow, a[9:0]};
            e.data = data_of(r, a);
            wq.push_back(e);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic full_load(int n2, logic commit_last, logic shadow);
        for (int r = 0; r < 3; r++) begin
            int n;
            n = (r == 2) ? n2 : P;
            for (int a = 0; a < n; a++) begin
                if (commit_last && r == 2 && a == n - 1) cfg_commit = 1'b1;
                send_beat(r, a, 1'b1, shadow);
                cfg_commit = 1'b0;
            end
        end
        if (!commit_last) begin
            cfg_commit = 1'b1;
            tick();
            cfg_commit = 1'b0;
        end
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic pulse_abort();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cycle_enable = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_region = 2'd0;
        cfg_addr = '0;
        cfg_data = '0;
        cfg_commit = 1'b0;
        cfg_abort = 1'b0;
        cmp_rden = 1'b1;
        cmp_rdaddr = 10'd400;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_bank", 32'(active_bank), 0);
        chk("rst_ready", 32'(cfg_ready), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_swap", 32'(swap_done), 0);
        chk("rst_wren", 32'(ram_wren), 0);
        chk("rst_wraddr", 32'(ram_wraddr), 0);
        chk("rst_wrdata", 32'(ram_wrdata), 0);
        chk("rden", 32'(ram_rden), 1);

        // 1: full load into bank 1, swap on the scan boundary
        pulse_start();
        chk("t1_ready", 32'(cfg_ready), 1);
        full_load(P, 1'b0, 1'b1);
        chk("t1_armed_ready", 32'(cfg_ready), 0);
        chk("t1_err", 32'(cfg_err), 0);
        chk("t1_rd_old", 32'(ram_rdaddr), 32'h190);
        cycle_enable = 1'b0;
        tick();
        chk("t1_bank_pre", 32'(active_bank), 0);
        sq.push_back(1'b1);
        tick();
        chk("t1_bank", 32'(active_bank), 1);
        chk("t1_rd_new", 32'(ram_rdaddr), 32'h590);
        tick();
        chk("t1_swap_low", 32'(swap_done), 0);
        cycle_enable = 1'b1;

        // 2: out-of-order beat on region 1
        pulse_start();
        chk("t2_err0", 32'(cfg_err), 0);
        for (int a = 0; a < 4; a++) send_beat(1, a, 1'b1, 1'b0);
        send_beat(1, 5, 1'b0, 1'b0);
        chk("t2_err", 32'(cfg_err), 1);
        chk("t2_ready", 32'(cfg_ready), 0);
        pulse_start();
        chk("t2_reload_err", 32'(cfg_err), 0);
        chk("t2_reload_ready", 32'(cfg_ready), 1);
        pulse_abort();
        chk("t2_idle", 32'(cfg_ready), 0);

        // 3: early commit, region 2 short by one point
        pulse_start();
        full_load(P - 1, 1'b0, 1'b0);
        chk("t3_err", 32'(cfg_err), 1);
        cycle_enable = 1'b0;
        repeat (4) tick();
        chk("t3_bank", 32'(active_bank), 1);
        cycle_enable = 1'b1;
        pulse_abort();
        chk("t3_err_kept", 32'(cfg_err), 1);

        // 4: abort while armed, then a scan boundary
        pulse_start();
        chk("t4_err0", 32'(cfg_err), 0);
        full_load(P, 1'b1, 1'b0);
        chk("t4_armed_ready", 32'(cfg_ready), 0);
        chk("t4_err", 32'(cfg_err), 0);
        pulse_abort();
        cycle_enable = 1'b0;
        repeat (4) tick();
        chk("t4_bank", 32'(active_bank), 1);
        cycle_enable = 1'b1;
        pulse_start();
        chk("t4_idle", 32'(cfg_ready), 1);
        pulse_abort();

        // 6: reset in the middle of a load
        pulse_start();
        for (int a = 0; a < 300; a++) send_beat(0, a, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_bank", 32'(active_bank), 0);
        chk("t6_ready", 32'(cfg_ready), 0);
        chk("t6_err", 32'(cfg_err), 0);
        chk("t6_wren", 32'(ram_wren), 0);
        chk("t6_wraddr", 32'(ram_wraddr), 0);
        chk("t6_wrdata", 32'(ram_wrdata), 0);
        chk("t6_rd", 32'(ram_rdaddr), 32'h190);
        tick();
        chk("t6_idle", 32'(cfg_ready), 0);

        // 5: commit mid-scan; reads stay on bank 0 until the fall
        pulse_start();
        full_load(P, 1'b0, 1'b1);
        repeat (3) tick();
        chk("t5_rd_old", 32'(ram_rdaddr), 32'h190);
        cycle_enable = 1'b0;
        tick();
        chk("t5_rd_fall", 32'(ram_rdaddr), 32'h190);
        sq.push_back(1'b1);
        tick();
        tick();
        cycle_enable = 1'b1;
        tick();
        chk("t5_rd_new", 32'(ram_rdaddr), 32'h590);
        chk("t5_bank", 32'(active_bank), 1);

        repeat (5) tick();
        chk("wq_empty", 32'(wq.size()), 0);
        chk("sq_empty", 32'(sq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
